// File: rtl/uart_tx_engine.sv
// UART transmitter fed by an upstream FIFO: start bit, 8 data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_engine #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_empty_n,
    input  logic [7:0] i_data,
    output logic       o_rd,
    output logic       o_uart_tx,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;

    state_t      state, state_next;
    logic [23:0] counter, counter_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shreg, shreg_next;
    logic        tx_reg, tx_next;
    logic        cell_done;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            counter <= 24'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            counter <= counter_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            tx_reg  <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // tx_next is the line level for the state being entered, so the line stays registered.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        tx_next      = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        cell_done = (counter == 24'd0);
        o_rd = ((state == IDLE) || ((state == STOP) && cell_done)) && i_empty_n && !i_reset;

        if (!cell_done && (state != IDLE))
            counter_next = counter - 24'd1;

        case (state)
            IDLE: begin
                tx_next      = 1'b1;
                bit_idx_next = 3'd0;
            end
            START: begin
                if (cell_done) begin
                    state_next   = DATA;
                    counter_next = RELOAD;
                    bit_idx_next = 3'd0;
                    tx_next      = shreg[0];
                end
            end
            DATA: begin
                if (cell_done) begin
                    counter_next = RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[7:1]};
                        tx_next      = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cell_done) begin
                    state_next   = STOP;
                    counter_next = RELOAD;
                    tx_next      = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cell_done) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // A pop overrides everything: from IDLE or the last stop cycle straight into START.
        if (o_rd) begin
            state_next   = START;
            counter_next = RELOAD;
            bit_idx_next = 3'd0;
            shreg_next   = i_data;
            tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next  = ^i_data;
`endif
        end
    end

    assign o_uart_tx = tx_reg;
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine at four clocks per bit.
// Also exercises the parity frames when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;

    localparam logic [23:0] CPB  = 24'd4;
    localparam int          CPBI = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPBI;

    logic       i_clk;
    logic       i_reset;
    logic       i_empty_n;
    logic [7:0] i_data;
    logic       o_rd;
    logic       o_uart_tx;
    logic       o_busy;

    int   total = 0;
    int   bad   = 0;
    logic last_parity;

    uart_tx_engine #(.CLOCKS_PER_BAUD(CPB)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_empty_n(i_empty_n),
        .i_data   (i_data),
        .o_rd     (o_rd),
        .o_uart_tx(o_uart_tx),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1 ns later.
    task automatic applyStimulus(input logic rst, input logic empty_n, input logic [7:0] data);
        @(negedge i_clk);
        i_reset   = rst;
        i_empty_n = empty_n;
        i_data    = data;
        #1;
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Walks one frame cycle by cycle starting the cycle after its capture edge.
    task automatic expectFrame(input string tag, input logic [7:0] b, input logic has_next,
                               input logic [7:0] next_b, input logic scramble);
        logic [7:0] d;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            d = has_next ? next_b : (scramble ? 8'($urandom) : 8'h00);
            applyStimulus(1'b0, has_next, d);
            checkOutput($sformatf("%s tx c%0d", tag, c), 32'(o_uart_tx), 32'(frameBit(b, c / CPBI)));
            checkOutput($sformatf("%s busy c%0d", tag, c), 32'(o_busy), 32'd1);
            checkOutput($sformatf("%s rd c%0d", tag, c), 32'(o_rd),
                        32'(has_next && (c == FRAME_CYCLES - 1)));
            if (c == 9 * CPBI + 1) last_parity = o_uart_tx;
        end
    endtask

    task automatic checkIdle(input string tag);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({tag, " idle tx"}, 32'(o_uart_tx), 32'd1);
        checkOutput({tag, " idle busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, " idle rd"}, 32'(o_rd), 32'd0);
    endtask

    initial begin
        int rd_seen;
        int tx_low_seen;
        int busy_seen;
        i_reset     = 1'b1;
        i_empty_n   = 1'b1;
        i_data      = 8'h55;
        last_parity = 1'b0;

        // Reset held with data waiting: no pops, line idle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h55);
            checkOutput("reset tx", 32'(o_uart_tx), 32'd1);
            checkOutput("reset busy", 32'(o_busy), 32'd0);
            checkOutput("reset rd", 32'(o_rd), 32'd0);
        end

        // Single byte 0x55.
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkOutput("b55 rd", 32'(o_rd), 32'd1);
        checkOutput("b55 pre tx", 32'(o_uart_tx), 32'd1);
        expectFrame("b55", 8'h55, 1'b0, 8'h00, 1'b0);
        checkIdle("b55");

        // Back-to-back 0xA5 then 0x3C.
        applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("bA5 rd", 32'(o_rd), 32'd1);
        expectFrame("bA5", 8'hA5, 1'b1, 8'h3C, 1'b0);
        expectFrame("b3C", 8'h3C, 1'b0, 8'h00, 1'b0);
        checkIdle("b3C");

        // Empty FIFO for 100 cycles.
        rd_seen = 0; tx_low_seen = 0; busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 8'($urandom));
            if (o_rd !== 1'b0) rd_seen++;
            if (o_uart_tx !== 1'b1) tx_low_seen++;
            if (o_busy !== 1'b0) busy_seen++;
        end
        checkOutput("empty rd cycles", 32'(rd_seen), 32'd0);
        checkOutput("empty tx low cycles", 32'(tx_low_seen), 32'd0);
        checkOutput("empty busy cycles", 32'(busy_seen), 32'd0);

        // Reset in the middle of a 0x00 frame, then 0x96 queued.
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("b00 rd", 32'(o_rd), 32'd1);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("b00 tx c%0d", c), 32'(o_uart_tx), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 8'h96);
        checkOutput("midreset rd", 32'(o_rd), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h96);
        checkOutput("midreset tx", 32'(o_uart_tx), 32'd1);
        checkOutput("midreset busy", 32'(o_busy), 32'd0);
        checkOutput("midreset rd after", 32'(o_rd), 32'd1);
        expectFrame("b96", 8'h96, 1'b0, 8'h00, 1'b0);
        checkIdle("b96");

        // i_data scrambled for the whole frame after capturing 0xC3.
        applyStimulus(1'b0, 1'b1, 8'hC3);
        checkOutput("bC3 rd", 32'(o_rd), 32'd1);
        expectFrame("bC3", 8'hC3, 1'b0, 8'h00, 1'b1);
        checkIdle("bC3");

`ifdef UART_TX_PARITY_EN
        applyStimulus(1'b0, 1'b1, 8'h07);
        checkOutput("b07 rd", 32'(o_rd), 32'd1);
        expectFrame("b07", 8'h07, 1'b0, 8'h00, 1'b0);
        checkOutput("b07 parity", 32'(last_parity), 32'd1);
        checkIdle("b07");
        applyStimulus(1'b0, 1'b1, 8'h03);
        checkOutput("b03 rd", 32'(o_rd), 32'd1);
        expectFrame("b03", 8'h03, 1'b0, 8'h00, 1'b0);
        checkOutput("b03 parity", 32'(last_parity), 32'd0);
        checkIdle("b03");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 24'd868, giving clocks per bit cell (100 MHz / 115200); legal range 2..2^24-1.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_empty_n  input  1  high when the upstream TX FIFO holds data.
REQ-005 SHALL have port i_data  input  8  byte at the FIFO head; valid whenever i_empty_n is high.
REQ-006 SHALL have port o_rd  output  1  FIFO pop strobe; high for exactly the cycle i_data is captured.
REQ-007 SHALL have port o_uart_tx  output  1  serial line; idles high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is in progress.

Function
REQ-009 SHALL send frames LSB-first as 1 start bit (0), 8 data bits, optional parity (REQ-024), and 1 stop bit (1).
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (present only when enabled) and STOP.
REQ-011 SHALL hold each bit cell for exactly CLOCKS_PER_BAUD cycles, using a 24-bit down-counter loaded with CLOCKS_PER_BAUD-1 that advances state at 0.
REQ-012 SHALL drive o_rd combinationally as (state==IDLE, or state==STOP with counter==0) && i_empty_n && !i_reset.
REQ-013 SHALL capture i_data into a shift register and enter START on the clock edge where o_rd is high.
REQ-014 SHALL drive o_uart_tx low beginning the cycle after the capture edge (latency 1 clock from o_rd).
REQ-015 SHALL use a 3-bit bit index in DATA and leave DATA after bit index 7's cell expires.
REQ-016 SHALL, at the end of STOP, go to START with no idle gap if i_empty_n is high, and otherwise go to IDLE.
REQ-017 SHALL take 10*CLOCKS_PER_BAUD cycles per frame (11*CLOCKS_PER_BAUD with parity) and SHALL support back-to-back frames at full line rate.
REQ-018 SHALL assert o_busy in every state other than IDLE.
REQ-019 SHALL never assert o_rd while i_empty_n is low, and SHALL never assert o_rd twice within one frame.
REQ-020 SHALL sample i_data only on the o_rd edge; changes to i_data mid-frame SHALL NOT affect the frame being sent.
REQ-021 SHALL register o_uart_tx, with no combinational path from any input to o_uart_tx.

Reset
REQ-022 SHALL, on i_reset high at a clock edge (including mid-frame), set state=IDLE, o_uart_tx=1, o_busy=0, counter=0 and bit index=0; any partial frame is abandoned.
REQ-023 SHALL hold o_rd=0 during every cycle i_reset is high.

Configuration
REQ-024 SHALL, when macro UART_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit, giving 11-bit frames.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, have no PARITY state or logic and use 10-bit frames; ports SHALL be identical in both builds.

Verification (CLOCKS_PER_BAUD=4)
REQ-026 SHALL cover single byte: FIFO holds 0x55, i_empty_n=1 for one cycle -> one o_rd pulse; line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; o_busy high for 40 cycles.
REQ-027 SHALL cover back-to-back: FIFO holds 0xA5 then 0x3C -> second o_rd in the final cycle of the first stop bit; 80 contiguous busy cycles; second start bit directly follows the first stop bit.
REQ-028 SHALL cover empty FIFO: i_empty_n=0 for 100 cycles -> o_rd never high, o_uart_tx constantly 1, o_busy 0.
REQ-029 SHALL cover reset mid-frame: i_reset pulsed at cycle 17 of a 0x00 frame -> o_uart_tx=1 and o_busy=0 the next cycle; the next queued byte begins a complete, correct frame.
REQ-030 SHALL cover parity (UART_TX_PARITY_EN defined): byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; each frame 44 cycles.
REQ-031 SHALL cover data hold: i_data toggled randomly after o_rd -> serialized bits equal the byte captured at o_rd.
